move_validator: RTL

Checks one proposed chess move against the board RAM and reports legal/illegal to the game controller. It sits between `control` and the validator read port of `memory_access`. It drives `validate_x`/`validate_y` through an `address_encoder` and reads `validate_square` back. It reads squares one at a time: source square, each intermediate path square, then the target square.

---
 rtl/move_validator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/move_validator.sv
// move_validator: checks one chess move against board RAM by reading source, path and target squares
// Ports: clk, reset (sync, active-high), start, piece_x/piece_y (source), move_x/move_y (target),
//        validate_square (RAM read data) -> validate_x/validate_y (registered read address),
//        busy, done (1-cycle pulse), valid and target_piece (held until the next done).
module move_validator #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] piece_x,
  input  logic [3:0] piece_y,
  input  logic [3:0] move_x,
  input  logic [3:0] move_y,
  input  logic [3:0] validate_square,
  output logic [3:0] validate_x,
  output logic [3:0] validate_y,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [3:0] target_piece
);
  typedef enum logic [2:0] {IDLE, SRC, GEOM, PATH, DST, DONE} state_t;
  state_t     state;
  logic [1:0] cnt;
  logic [3:0] px, py, mx, my, src;
  logic [2:0] n;
  logic       pawn, cap;
  logic       rd, black, bad_src, knight, rook, bish, fwd, fwd2, pawn_ok, geo_ok, opp, legal, reading;
  logic [4:0] dx, dy;
  logic [2:0] adx, ady, mxd, steps;
  logic [3:0] kind, sx, sy;
  always_comb begin
    rd      = cnt == 2'(READ_LATENCY);
    reading = state == SRC || state == PATH || state == DST;
    dx      = {1'b0, mx} - {1'b0, px};
    dy      = {1'b0, my} - {1'b0, py};
    adx     = dx[4] ? 3'(-dx) : dx[2:0];
    ady     = dy[4] ? 3'(-dy) : dy[2:0];
    mxd     = adx > ady ? adx : ady;
    sx      = dx == 5'd0 ? 4'h0 : dx[4] ? 4'hf : 4'h1;
    sy      = dy == 5'd0 ? 4'h0 : dy[4] ? 4'hf : 4'h1;
    black   = src <= 4'd6;
    kind    = black ? src : src - 4'd6;
    bad_src = src == 4'd0 || src > 4'd12;
    knight  = (adx == 3'd1 && ady == 3'd2) || (adx == 3'd2 && ady == 3'd1);
    rook    = dx == 5'd0 || dy == 5'd0;
    bish    = adx == ady;
    // black pawns advance +y from row 1, white pawns -y from row 6
    fwd     = black ? dy == 5'd1 : dy == 5'h1f;
    fwd2    = black ? (dy == 5'd2 && py == 4'd1) : (dy == 5'h1e && py == 4'd6);
    pawn_ok = (dx == 5'd0 && (fwd || fwd2)) || (adx == 3'd1 && fwd);
    geo_ok  = kind == 4'd1 ? pawn_ok : kind == 4'd2 ? knight : kind == 4'd3 ? bish :
              kind == 4'd4 ? rook : kind == 4'd5 ? (rook || bish) : mxd == 3'd1;
    // knight jumps; every other legal geometry walks max(|dx|,|dy|)-1 squares between
    steps   = kind == 4'd2 ? 3'd0 : mxd - 3'd1;
    opp     = black ? (validate_square >= 4'd7 && validate_square <= 4'd12)
                    : (validate_square >= 4'd1 && validate_square <= 4'd6);
    legal   = pawn ? (cap ? opp : validate_square == 4'd0) : (validate_square == 4'd0 || opp);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {px, py, mx, my, src} <= '0;
      n <= '0;
      {pawn, cap} <= '0;
      {validate_x, validate_y, target_piece} <= '0;
      {busy, done, valid} <= '0;
    end else begin
      done <= 1'b0;
      cnt <= reading && !rd ? cnt + 2'd1 : 2'd0;
      case (state)
        IDLE: if (start) begin
          {px, py, mx, my} <= {piece_x, piece_y, move_x, move_y};
          busy <= 1'b1;
          if (piece_x[3] || piece_y[3] || move_x[3] || move_y[3] || (piece_x == move_x && piece_y == move_y)) begin
            state <= DONE;
            done <= 1'b1;
            valid <= 1'b0;
            target_piece <= 4'd0;
          end else begin
            state <= SRC;
            validate_x <= piece_x;
            validate_y <= piece_y;
          end
        end
        SRC: if (rd) begin
          src <= validate_square;
          state <= GEOM;
        end
        GEOM: begin
          pawn <= kind == 4'd1;
          cap <= dx != 5'd0;
          n <= steps;
          if (bad_src || !geo_ok) begin
            state <= DONE;
            done <= 1'b1;
            valid <= 1'b0;
            target_piece <= 4'd0;
          end else if (steps == 3'd0) begin
            state <= DST;
            validate_x <= mx;
            validate_y <= my;
          end else begin
            state <= PATH;
            validate_x <= px + sx;
            validate_y <= py + sy;
          end
        end
        PATH: if (rd) begin
          if (validate_square != 4'd0) begin
            state <= DONE;
            done <= 1'b1;
            valid <= 1'b0;
            target_piece <= 4'd0;
          end else if (n == 3'd1) begin
            state <= DST;
            validate_x <= mx;
            validate_y <= my;
          end else begin
            n <= n - 3'd1;
            validate_x <= validate_x + sx;
            validate_y <= validate_y + sy;
          end
        end
        DST: if (rd) begin
          state <= DONE;
          done <= 1'b1;
          valid <= legal && validate_square <= 4'd12;
          target_piece <= validate_square;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
